// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
package mux_rr_arbiter_pkg;

  // Arbiter FSM states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2
  } state_e;

  // Side identifiers, also used directly as the mux select value.
  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

endpackage : mux_rr_arbiter_pkg

// File: rtl/mux_rr_arbiter_mux2.sv
// 1-bit 2:1 mux cell: y = sel ? b : a.
module mux_rr_arbiter_mux2 (
  input  logic a_i,
  input  logic b_i,
  input  logic sel_i,
  output logic y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule : mux_rr_arbiter_mux2

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter owning the shared 2:1 datapath mux.
// Grants A or B exclusively, forces a handover after MAX_HOLD held cycles
// while the other side waits, and steers the granted payload to data_out.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4,   // 0 disables the forced handover
  parameter int CNT_W    = 3    // 2**CNT_W must be >= MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic             busy,
  output logic [WIDTH-1:0] data_out
);

  // Saturation point of the hold counter; pinned at zero when unlimited.
  localparam logic [CNT_W-1:0] CNT_MAX = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic             gnt_a_q, gnt_b_q;
  logic             hold_expired;

  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == CNT_MAX);

  // Next-state, hold counter, 'last' and select decision.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case/if tree leaves it unassigned and infers a latch.
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    sel_d      = sel_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_a && req_b)   state_d = (last_q == SIDE_B) ? ST_GNT_A : ST_GNT_B;
        else if (req_a)       state_d = ST_GNT_A;
        else if (req_b)       state_d = ST_GNT_B;
      end
      ST_GNT_A: begin
        if (!req_a)                    state_d = req_b ? ST_GNT_B : ST_IDLE;
        else if (req_b && hold_expired) state_d = ST_GNT_B;
      end
      ST_GNT_B: begin
        if (!req_b)                    state_d = req_a ? ST_GNT_A : ST_IDLE;
        else if (req_a && hold_expired) state_d = ST_GNT_A;
      end
      default: state_d = ST_IDLE;
    endcase

    // Counter restarts on any state change; otherwise counts up and saturates
    // so a late competitor can take over on the very next edge.
    if (state_d != state_q) begin
      hold_cnt_d = '0;
      if (state_d == ST_GNT_A) begin
        last_d = SIDE_A;
        sel_d  = SIDE_A;
      end else if (state_d == ST_GNT_B) begin
        last_d = SIDE_B;
        sel_d  = SIDE_B;
      end
    end else if (hold_cnt_q != CNT_MAX) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
  end

  // State register with asynchronous reset; grants are registered copies of
  // the next-state decode so they never glitch on state transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments in clocked blocks keep every register
      // updating from the same pre-edge values, independent of statement order.
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      last_q     <= SIDE_B;   // A wins the first tie after reset
      sel_q      <= SIDE_A;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      gnt_a_q    <= (state_d == ST_GNT_A);
      gnt_b_q    <= (state_d == ST_GNT_B);
    end
  end

  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign sel   = sel_q;
  assign busy  = gnt_a_q | gnt_b_q;

  // Shared datapath: one mux cell per bit, all steered by the registered select.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux_rr_arbiter_mux2 u_mux (
      .a_i  (data_a[i]),
      .b_i  (data_b[i]),
      .sel_i(sel_q),
      .y_o  (data_out[i])
    );
  end

endmodule : mux_rr_arbiter

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, async reset
// corner, then a random run against an independent behavioural model.
module tb_mux_rr_arbiter;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 3;
  localparam logic [WIDTH-1:0] DATA_A = 8'hAA;
  localparam logic [WIDTH-1:0] DATA_B = 8'h55;

  logic             clk;
  logic             rst;
  logic             req_a, req_b;
  logic [WIDTH-1:0] data_a, data_b, data_out;
  logic             gnt_a, gnt_b, sel, busy;

  mux_rr_arbiter #(
    .WIDTH   (WIDTH),
    .MAX_HOLD(MAX_HOLD),
    .CNT_W   (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_a   (req_a),
    .req_b   (req_b),
    .data_a  (data_a),
    .data_b  (data_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .sel     (sel),
    .busy    (busy),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic  ra, rb;
    logic  ga, gb, s;
    string name;
  } vec_t;

  typedef struct {
    logic  ga, gb, s;
    string name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks;
  int   n_errors;

  // Behavioural reference model: owner 0=none 1=A 2=B, unbounded held count.
  int   m_owner, m_held, m_last;
  logic m_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input string name, input logic ra, input logic rb,
                     input logic ga, input logic gb, input logic s);
    vec_t v;
    v.ra = ra; v.rb = rb; v.ga = ga; v.gb = gb; v.s = s; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input string name, input logic ga, input logic gb, input logic s);
    exp_t e;
    e.ga = ga; e.gb = gb; e.s = s; e.name = name;
    sb.push_back(e);
  endtask

  // Advance one edge and compare the DUT against the oldest expectation.
  task automatic tick_and_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: no expectation queued (t=%0t)", $time);
    end else begin
      e = sb.pop_front();
      check({e.name, ".gnt_a"}, 32'(gnt_a), 32'(e.ga));
      check({e.name, ".gnt_b"}, 32'(gnt_b), 32'(e.gb));
      check({e.name, ".sel"},   32'(sel),   32'(e.s));
      check({e.name, ".busy"},  32'(busy),  32'(e.ga | e.gb));
      check({e.name, ".data"},  32'(data_out), 32'(e.s ? DATA_B : DATA_A));
    end
  endtask

  function automatic void model_reset();
    m_owner = 0;
    m_held  = 0;
    m_last  = 2;
    m_sel   = 1'b0;
  endfunction

  function automatic void model_step(input logic ra, input logic rb);
    int nxt;
    nxt = m_owner;
    case (m_owner)
      0: nxt = (ra && rb) ? ((m_last == 2) ? 1 : 2) : (ra ? 1 : (rb ? 2 : 0));
      1: nxt = !ra ? (rb ? 2 : 0) : ((rb && m_held >= MAX_HOLD - 1) ? 2 : 1);
      2: nxt = !rb ? (ra ? 1 : 0) : ((ra && m_held >= MAX_HOLD - 1) ? 1 : 2);
      default: nxt = 0;
    endcase
    if (nxt != m_owner) begin
      m_held = 0;
      if (nxt != 0) begin
        m_last = nxt;
        m_sel  = (nxt == 2);
      end
    end else begin
      m_held = m_held + 1;
    end
    m_owner = nxt;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    data_a   = DATA_A;
    data_b   = DATA_B;
    rst      = 1'b1;
    req_a    = 1'b1;
    req_b    = 1'b1;

    // Reset holds everything low even with both sides requesting.
    repeat (2) @(posedge clk);
    #1;
    check("reset.gnt_a", 32'(gnt_a), 32'd0);
    check("reset.gnt_b", 32'(gnt_b), 32'd0);
    check("reset.sel",   32'(sel),   32'd0);
    check("reset.busy",  32'(busy),  32'd0);
    check("reset.data",  32'(data_out), 32'(DATA_A));
    rst = 1'b0;

    // Directed table: inputs applied before an edge, outputs after it.
    add("rst_release_tie", 1, 1, 1, 0, 0);
    add("drop_both",       0, 0, 0, 0, 0);
    add("single_b",        0, 1, 0, 1, 1);
    add("drop_b_sel_held", 0, 0, 0, 0, 1);
    add("tie_after_b",     1, 1, 1, 0, 0);
    add("hold_a_1",        1, 1, 1, 0, 0);
    add("hold_a_2",        1, 1, 1, 0, 0);
    add("hold_a_3",        1, 1, 1, 0, 0);
    add("force_to_b",      1, 1, 0, 1, 1);
    add("hold_b_1",        1, 1, 0, 1, 1);
    add("hold_b_2",        1, 1, 0, 1, 1);
    add("hold_b_3",        1, 1, 0, 1, 1);
    add("force_to_a",      1, 1, 1, 0, 0);
    add("hold_a2_1",       1, 1, 1, 0, 0);
    add("hold_a2_2",       1, 1, 1, 0, 0);
    add("hold_a2_3",       1, 1, 1, 0, 0);
    add("force_to_b2",     1, 1, 0, 1, 1);
    add("release_b_to_a",  1, 0, 1, 0, 0);
    add("release_a_to_b",  0, 1, 0, 1, 1);
    add("idle_again",      0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) add("a_alone", 1, 0, 1, 0, 0);
    add("late_b_takes",    1, 1, 0, 1, 1);
    add("final_idle",      0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      req_a = vecs[i].ra;
      req_b = vecs[i].rb;
      push_exp(vecs[i].name, vecs[i].ga, vecs[i].gb, vecs[i].s);
      tick_and_check();
    end

    // Async reset pulse between edges while B owns the path.
    req_a = 1'b0;
    req_b = 1'b1;
    push_exp("pre_async_b", 0, 1, 1);
    tick_and_check();
    #3;
    rst = 1'b1;
    #1;
    check("async_rst.gnt_b", 32'(gnt_b), 32'd0);
    check("async_rst.busy",  32'(busy),  32'd0);
    check("async_rst.sel",   32'(sel),   32'd0);
    check("async_rst.data",  32'(data_out), 32'(DATA_A));
    @(posedge clk);
    #1;
    rst   = 1'b0;
    req_a = 1'b1;
    req_b = 1'b1;
    push_exp("post_async_tie_a", 1, 0, 0);
    tick_and_check();

    // Random run against the model; requests toggle with low probability so
    // long contended holds and forced handovers actually occur.
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) req_a = ~req_a;
      if ($urandom_range(0, 3) == 0) req_b = ~req_b;
      model_step(req_a, req_b);
      push_exp("random", (m_owner == 1), (m_owner == 2), m_sel);
      tick_and_check();
      check("random.mutex", 32'(gnt_a & gnt_b), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mux_rr_arbiter
